// File: rtl/clock_ui_ctrl.sv
// Alarm-clock UI controller: button-driven BCD time/alarm editing, alarm ringing with auto-off.
// Optional snooze state is compiled in with CLOCK_UI_SNOOZE_EN.
module clock_ui_ctrl #(
  parameter int RING_SECS    = 60,
  parameter int SNOOZE_SECS  = 300,
  parameter int EDIT_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic       btn_stop,
  input  logic       alarm_in,
  input  logic [1:0] cur_hour_msb,
  input  logic [3:0] cur_hour_lsb,
  input  logic [3:0] cur_min_msb,
  input  logic [3:0] cur_min_lsb,
  output logic [1:0] inhour_msb,
  output logic [3:0] inhour_lsb,
  output logic [3:0] inmin_msb,
  output logic [3:0] inmin_lsb,
  output logic       set_time,
  output logic       set_alarm,
  output logic       alm_on,
  output logic       alm_off,
  output logic       buzzer,
  output logic [2:0] ui_state
);

  typedef enum logic [2:0] {
    RUN = 3'd0, T_HR = 3'd1, T_MIN = 3'd2, A_HR = 3'd3,
    A_MIN = 3'd4, RINGING = 3'd5, SNOOZE = 3'd6
  } state_t;

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int EW = $clog2(EDIT_TIMEOUT + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [EW-1:0] EDIT_LAST = EW'(EDIT_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    hrMsb_q, hrMsb_d, shHrMsb_q, shHrMsb_d;
  logic [3:0]    hrLsb_q, hrLsb_d, shHrLsb_q, shHrLsb_d;
  logic [3:0]    minMsb_q, minMsb_d, shMinMsb_q, shMinMsb_d;
  logic [3:0]    minLsb_q, minLsb_d, shMinLsb_q, shMinLsb_d;
  logic          almOn_q, almOn_d, setTime_q, setTime_d;
  logic          setAlarm_q, setAlarm_d, almOff_q, almOff_d;
  logic          buzzer_q, buzzer_d;
  logic [RW-1:0] ringCnt_q, ringCnt_d;
  logic [EW-1:0] editCnt_q, editCnt_d;
  logic [1:0]    holdoff_q, holdoff_d;
  logic          anyBtn, selStop, selMode, selOk, selInc;
  logic          editState, almEdit;
`ifdef CLOCK_UI_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECS - 1);
  logic [SW-1:0] snzCnt_q, snzCnt_d;
`endif

  function automatic logic [5:0] incHour(input logic [1:0] msb, input logic [3:0] lsb);
    logic [5:0] r;
    if (msb == 2'd2 && lsb == 4'd3) r = 6'h00;
    else if (lsb == 4'd9)           r = {msb + 2'd1, 4'd0};
    else                            r = {msb, lsb + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] incMin(input logic [3:0] msb, input logic [3:0] lsb);
    logic [7:0] r;
    if (lsb == 4'd9) r = {(msb == 4'd5) ? 4'd0 : msb + 4'd1, 4'd0};
    else             r = {msb, lsb + 4'd1};
    return r;
  endfunction

  // One button per cycle, stop > mode > ok > inc.
  assign anyBtn  = btn_stop | btn_mode | btn_ok | btn_inc;
  assign selStop = btn_stop;
  assign selMode = btn_mode & ~btn_stop;
  assign selOk   = btn_ok & ~btn_stop & ~btn_mode;
  assign selInc  = btn_inc & ~btn_stop & ~btn_mode & ~btn_ok;
  assign editState = (state_q == T_HR) || (state_q == T_MIN) ||
                     (state_q == A_HR) || (state_q == A_MIN);
  assign almEdit   = (state_q == A_HR) || (state_q == A_MIN);

  always_comb begin
    state_d    = state_q;
    hrMsb_d    = hrMsb_q;    hrLsb_d    = hrLsb_q;
    minMsb_d   = minMsb_q;   minLsb_d   = minLsb_q;
    shHrMsb_d  = shHrMsb_q;  shHrLsb_d  = shHrLsb_q;
    shMinMsb_d = shMinMsb_q; shMinLsb_d = shMinLsb_q;
    almOn_d    = almOn_q;
    setTime_d  = 1'b0;
    setAlarm_d = 1'b0;
    almOff_d   = 1'b0;
    ringCnt_d  = ringCnt_q;
    editCnt_d  = '0;
    holdoff_d  = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
`ifdef CLOCK_UI_SNOOZE_EN
    snzCnt_d   = snzCnt_q;
`endif
    case (state_q)
      RUN: begin
        if (selMode) begin
          state_d  = T_HR;
          hrMsb_d  = cur_hour_msb; hrLsb_d = cur_hour_lsb;
          minMsb_d = cur_min_msb;  minLsb_d = cur_min_lsb;
        end else if (alarm_in && almOn_q && holdoff_q == 2'd0) begin
          state_d   = RINGING;
          ringCnt_d = '0;
        end else if (selInc) begin
          almOn_d = ~almOn_q;
        end
      end
      T_HR, T_MIN, A_HR, A_MIN: begin
        if (anyBtn) begin
          if (selMode && !almEdit) begin
            state_d  = A_HR;
            hrMsb_d  = shHrMsb_q;  hrLsb_d = shHrLsb_q;
            minMsb_d = shMinMsb_q; minLsb_d = shMinLsb_q;
          end else if (selMode) begin
            state_d = RUN;
          end else if (selOk && state_q == T_HR) begin
            state_d = T_MIN;
          end else if (selOk && state_q == A_HR) begin
            state_d = A_MIN;
          end else if (selOk && state_q == T_MIN) begin
            state_d   = RUN;
            setTime_d = 1'b1;
          end else if (selOk) begin
            state_d    = RUN;
            setAlarm_d = 1'b1;
            almOn_d    = 1'b1;
            shHrMsb_d  = hrMsb_q;  shHrLsb_d  = hrLsb_q;
            shMinMsb_d = minMsb_q; shMinLsb_d = minLsb_q;
          end else if (selInc && (state_q == T_HR || state_q == A_HR)) begin
            {hrMsb_d, hrLsb_d} = incHour(hrMsb_q, hrLsb_q);
          end else if (selInc) begin
            {minMsb_d, minLsb_d} = incMin(minMsb_q, minLsb_q);
          end
        end else if (sec_tick) begin
          if (editCnt_q >= EDIT_LAST) state_d = RUN;
          else                        editCnt_d = editCnt_q + EW'(1);
        end else begin
          editCnt_d = editCnt_q;
        end
      end
      RINGING: begin
        if (selStop) begin
          state_d   = RUN;
          almOff_d  = 1'b1;
          holdoff_d = 2'd2;
`ifdef CLOCK_UI_SNOOZE_EN
        end else if (selOk) begin
          state_d   = SNOOZE;
          almOff_d  = 1'b1;
          holdoff_d = 2'd2;
          snzCnt_d  = '0;
`endif
        end else if (sec_tick) begin
          if (ringCnt_q >= RING_LAST) begin
            state_d   = RUN;
            almOff_d  = 1'b1;
            holdoff_d = 2'd2;
          end else begin
            ringCnt_d = ringCnt_q + RW'(1);
          end
        end
      end
`ifdef CLOCK_UI_SNOOZE_EN
      SNOOZE: begin
        if (selStop) begin
          state_d = RUN;
        end else if (sec_tick) begin
          if (snzCnt_q >= SNZ_LAST) begin
            state_d   = RINGING;
            ringCnt_d = '0;
          end else begin
            snzCnt_d = snzCnt_q + SW'(1);
          end
        end
      end
`endif
      default: state_d = RUN;
    endcase
    buzzer_d = (state_d == RINGING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      hrMsb_q    <= '0; hrLsb_q    <= '0; minMsb_q   <= '0; minLsb_q   <= '0;
      shHrMsb_q  <= '0; shHrLsb_q  <= '0; shMinMsb_q <= '0; shMinLsb_q <= '0;
      almOn_q    <= 1'b0;
      setTime_q  <= 1'b0;
      setAlarm_q <= 1'b0;
      almOff_q   <= 1'b0;
      buzzer_q   <= 1'b0;
      ringCnt_q  <= '0;
      editCnt_q  <= '0;
      holdoff_q  <= 2'd0;
`ifdef CLOCK_UI_SNOOZE_EN
      snzCnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hrMsb_q    <= hrMsb_d;   hrLsb_q    <= hrLsb_d;
      minMsb_q   <= minMsb_d;  minLsb_q   <= minLsb_d;
      shHrMsb_q  <= shHrMsb_d; shHrLsb_q  <= shHrLsb_d;
      shMinMsb_q <= shMinMsb_d; shMinLsb_q <= shMinLsb_d;
      almOn_q    <= almOn_d;
      setTime_q  <= setTime_d;
      setAlarm_q <= setAlarm_d;
      almOff_q   <= almOff_d;
      buzzer_q   <= buzzer_d;
      ringCnt_q  <= ringCnt_d;
      editCnt_q  <= editCnt_d;
      holdoff_q  <= holdoff_d;
`ifdef CLOCK_UI_SNOOZE_EN
      snzCnt_q   <= snzCnt_d;
`endif
    end
  end

  assign inhour_msb = hrMsb_q;
  assign inhour_lsb = hrLsb_q;
  assign inmin_msb  = minMsb_q;
  assign inmin_lsb  = minLsb_q;
  assign set_time   = setTime_q;
  assign set_alarm  = setAlarm_q;
  assign alm_on     = almOn_q;
  assign alm_off    = almOff_q;
  assign buzzer     = buzzer_q;
  assign ui_state   = state_q;

endmodule

// File: tb/tb_clock_ui_ctrl.sv
// Directed self-checking bench for clock_ui_ctrl (RING_SECS=4, SNOOZE_SECS=5, EDIT_TIMEOUT=3).
// Snooze expectations follow CLOCK_UI_SNOOZE_EN.
module tb_clock_ui_ctrl;

  logic       clk, reset, secTick, btnMode, btnInc, btnOk, btnStop, alarmIn;
  logic [1:0] curHourMsb;
  logic [3:0] curHourLsb, curMinMsb, curMinLsb;
  logic [1:0] inhourMsb;
  logic [3:0] inhourLsb, inminMsb, inminLsb;
  logic       setTime, setAlarm, almOn, almOff, buzzer;
  logic [2:0] uiState;
  logic [13:0] editVal;
  int total = 0;
  int bad = 0;

  clock_ui_ctrl #(.RING_SECS(4), .SNOOZE_SECS(5), .EDIT_TIMEOUT(3)) dut (
    .clk(clk), .reset(reset), .sec_tick(secTick),
    .btn_mode(btnMode), .btn_inc(btnInc), .btn_ok(btnOk), .btn_stop(btnStop),
    .alarm_in(alarmIn),
    .cur_hour_msb(curHourMsb), .cur_hour_lsb(curHourLsb),
    .cur_min_msb(curMinMsb), .cur_min_lsb(curMinLsb),
    .inhour_msb(inhourMsb), .inhour_lsb(inhourLsb),
    .inmin_msb(inminMsb), .inmin_lsb(inminLsb),
    .set_time(setTime), .set_alarm(setAlarm),
    .alm_on(almOn), .alm_off(almOff), .buzzer(buzzer), .ui_state(uiState)
  );

  assign editVal = {inhourMsb, inhourLsb, inminMsb, inminLsb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of button/tick pulses, then release them 1 time unit after the edge.
  task applyStimulus(input logic m, input logic i, input logic o, input logic s, input logic t);
    btnMode = m; btnInc = i; btnOk = o; btnStop = s; secTick = t;
    @(posedge clk);
    #1;
    btnMode = 1'b0; btnInc = 1'b0; btnOk = 1'b0; btnStop = 1'b0; secTick = 1'b0;
  endtask

  task checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; alarmIn = 1'b0;
    btnMode = 1'b0; btnInc = 1'b0; btnOk = 1'b0; btnStop = 1'b0; secTick = 1'b0;
    {curHourMsb, curHourLsb, curMinMsb, curMinLsb} = 14'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", 16'(uiState), 16'd0);
    checkOutput("rst_edit", 16'(editVal), 16'h0000);
    checkOutput("rst_almon", 16'(almOn), 16'd0);
    checkOutput("rst_buzzer", 16'(buzzer), 16'd0);
    checkOutput("rst_settime", 16'(setTime), 16'd0);
    reset = 1'b0;
    $display("[TB] time edit");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("te_state_thr", 16'(uiState), 16'd1);
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("te_hr3", 16'(editVal), 16'h0300);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("te_state_tmin", 16'(uiState), 16'd2);
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("te_pre_settime", 16'(setTime), 16'd0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("te_settime", 16'(setTime), 16'd1);
    checkOutput("te_val", 16'(editVal), 16'h0302);
    checkOutput("te_run", 16'(uiState), 16'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("te_settime_1cyc", 16'(setTime), 16'd0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("te_ahr_shadow", 16'(editVal), 16'h0000);
    checkOutput("te_state_ahr", 16'(uiState), 16'd3);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("te_abort_run", 16'(uiState), 16'd0);
    checkOutput("te_abort_nocommit", 16'(setAlarm), 16'd0);
    {curHourMsb, curHourLsb, curMinMsb, curMinLsb} = 14'h0302;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("te_reload_cur", 16'(editVal), 16'h0302);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] alarm edit and hour wrap");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (23) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ae_hr23", 16'(editVal), 16'h2300);
    applyStimulus(0, 0, 1, 0, 0);
    repeat (59) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ae_2359", 16'(editVal), 16'h2359);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("ae_setalarm", 16'(setAlarm), 16'd1);
    checkOutput("ae_almon", 16'(almOn), 16'd1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ae_shadow_load", 16'(editVal), 16'h2359);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ae_hr_wrap", 16'(editVal), 16'h0059);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ae_min_wrap", 16'(editVal), 16'h0000);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("ae_setalarm2", 16'(setAlarm), 16'd1);
    checkOutput("ae_almon2", 16'(almOn), 16'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ae_setalarm_1cyc", 16'(setAlarm), 16'd0);

    $display("[TB] ring and auto-off");
    alarmIn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rg_buzzer_on", 16'(buzzer), 16'd1);
    checkOutput("rg_state", 16'(uiState), 16'd5);
    repeat (3) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rg_still_ringing", 16'(buzzer), 16'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rg_almoff", 16'(almOff), 16'd1);
    checkOutput("rg_buzzer_off", 16'(buzzer), 16'd0);
    checkOutput("rg_run", 16'(uiState), 16'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rg_almoff_1cyc", 16'(almOff), 16'd0);
    checkOutput("rg_holdoff1", 16'(buzzer), 16'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rg_holdoff2", 16'(buzzer), 16'd0);
    alarmIn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] priority and abandon");
    alarmIn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    alarmIn = 1'b0;
    checkOutput("pr_ringing", 16'(uiState), 16'd5);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("pr_almoff", 16'(almOff), 16'd1);
    checkOutput("pr_almon_kept", 16'(almOn), 16'd1);
    checkOutput("pr_run", 16'(uiState), 16'd0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("to_not_yet", 16'(uiState), 16'd2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("to_run", 16'(uiState), 16'd0);
    checkOutput("to_no_settime", 16'(setTime), 16'd0);
    checkOutput("to_edit_kept", 16'(editVal), 16'h0302);

    $display("[TB] snooze");
    alarmIn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    alarmIn = 1'b0;
    applyStimulus(0, 0, 1, 0, 0);
`ifdef CLOCK_UI_SNOOZE_EN
    checkOutput("sz_almoff", 16'(almOff), 16'd1);
    checkOutput("sz_buzzer_off", 16'(buzzer), 16'd0);
    checkOutput("sz_state", 16'(uiState), 16'd6);
    repeat (4) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("sz_waiting", 16'(buzzer), 16'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("sz_rering", 16'(buzzer), 16'd1);
    checkOutput("sz_ring_state", 16'(uiState), 16'd5);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("sz_stop_run", 16'(uiState), 16'd0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    alarmIn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    alarmIn = 1'b0;
`else
    checkOutput("sz_ok_ignored", 16'(uiState), 16'd5);
    checkOutput("sz_no_almoff", 16'(almOff), 16'd0);
    checkOutput("sz_still_buzz", 16'(buzzer), 16'd1);
`endif

    $display("[TB] reset mid-ring");
    checkOutput("mr_ringing", 16'(buzzer), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr_buzzer", 16'(buzzer), 16'd0);
    checkOutput("mr_state", 16'(uiState), 16'd0);
    checkOutput("mr_no_almoff", 16'(almOff), 16'd0);
    @(posedge clk);
    #1;
    checkOutput("mr_no_almoff2", 16'(almOff), 16'd0);
    checkOutput("mr_almon_clr", 16'(almOn), 16'd0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
